// File: rtl/fetch_pkg.sv
// fetch_pkg: tile and data sizing shared by the fetch logic and the tile streamer
package fetch_pkg;
  localparam int DATA_WIDTH = 256;
  localparam int WORDS_PER_TILE = 32;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int TILE_PTR_W = ptr_w(WORDS_PER_TILE);
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through synchronous FIFO, power-of-two depth, caller guarantees legal push/pop
module sync_fifo_fwft
  import fetch_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = fetch_pkg::DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = ptr_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign dout  = mem[rd_ptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/fetch_tile_streamer.sv
// fetch_tile_streamer: aligns BRAM Port-B reads, buffers them FWFT and streams tiles with tile-granular fetch credit
module fetch_tile_streamer
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH     = fetch_pkg::DATA_WIDTH,
  parameter int WORDS_PER_TILE = fetch_pkg::WORDS_PER_TILE,
  parameter int READ_LATENCY   = 1,
  parameter int FIFO_DEPTH     = 64,
  parameter int CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_fetch_in,
  input  logic                        bram_en_in,
  input  logic [DATA_WIDTH-1:0]       bram_dout,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        fetch_allow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]            tile_count,
  output logic                        err_overrun,
  output logic                        err_overflow,
  output logic                        err_unexpected
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = ptr_w(WORDS_PER_TILE);
  logic [READ_LATENCY-1:0] en_sr;
  logic [CW-1:0] outstanding;
  logic [CW:0] used;
  logic [PW-1:0] pw;
  logic cap_valid, pop, push, full, empty, start_ok;
  assign cap_valid   = en_sr[READ_LATENCY-1];
  assign pop         = out_valid && out_ready;
  assign push        = cap_valid && (!full || pop);
  assign used        = {1'b0, fifo_count} + {1'b0, outstanding};
  assign fetch_allow = used <= (CW+1)'(FIFO_DEPTH - WORDS_PER_TILE);
  assign start_ok    = start_fetch_in && fetch_allow;
  assign out_valid   = !empty;
  assign out_last    = out_valid && pw == PW'(WORDS_PER_TILE - 1);
  sync_fifo_fwft #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (bram_dout),
    .dout (out_data),
    .count(fifo_count),
    .full (full),
    .empty(empty)
  );
  always_ff @(posedge clk)
    if (rst) begin
      en_sr          <= '0;
      outstanding    <= '0;
      pw             <= '0;
      tile_count     <= '0;
      err_overrun    <= 1'b0;
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      en_sr          <= READ_LATENCY'({en_sr, bram_en_in});
      outstanding    <= outstanding + (start_ok ? CW'(WORDS_PER_TILE) : '0) - CW'(cap_valid && outstanding != '0);
      pw             <= pop ? (out_last ? '0 : pw + PW'(1)) : pw;
      tile_count     <= tile_count + CNT_W'(pop && out_last);
      err_overrun    <= err_overrun | (start_fetch_in && !fetch_allow);
      err_overflow   <= err_overflow | (cap_valid && full && !pop);
      err_unexpected <= err_unexpected | (cap_valid && outstanding == '0);
    end
endmodule

// File: doc/fetch_tile_streamer.md
Name: fetch_tile_streamer

Overview:
- Downstream consumer of the fetch-logic + W_B_I_Buffer pair.
- Aligns the 256-bit Port-B read data to the BRAM read latency and buffers it in a first-word-fall-through FIFO.
- Re-emits the data as a valid/ready stream with a per-tile last marker for the compute array.
- Issues tile-granular credit (fetch_allow) so start_fetch is only pulsed when one whole tile is guaranteed to fit.

Parameters:
- DATA_WIDTH, 256, width of BRAM Port-B word and output data.
- WORDS_PER_TILE, 32, BRAM reads per tile; equals the fetch logic's NUM_FETCHES_PER_TILE.
- READ_LATENCY, 1, cycles from bram_en to valid doutb; legal range 1..3.
- FIFO_DEPTH, 64, power of two, must be >= WORDS_PER_TILE.
- CNT_W, 16, width of tile_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_fetch_in  in  1  same pulse driven to the fetch logic's start_fetch; reserves one tile of credit.
- bram_en_in  in  1  Port-B enable issued by the fetch logic (one read per high cycle).
- bram_dout  in  DATA_WIDTH  Port-B doutb.
- out_data  out  DATA_WIDTH  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accept.
- out_last  out  1  head word is the final word of a tile.
- fetch_allow  out  1  a new tile may be started this cycle.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently stored.
- tile_count  out  CNT_W  tiles fully popped; wraps modulo 2^CNT_W.
- err_overrun  out  1  sticky: start_fetch_in seen while fetch_allow low.
- err_overflow  out  1  sticky: capture attempted into a full FIFO with no same-cycle pop.
- err_unexpected  out  1  sticky: capture occurred while outstanding == 0.

Behaviour:
- Reset:
  - FIFO pointers and count, outstanding, pop word counter, tile_count, the capture pipeline and all err_* flags clear to 0.
  - Outputs after reset: out_valid=0, out_last=0, fetch_allow=1.
  - Reset mid-tile flushes the FIFO and discards in-flight reads; the upstream fetch logic must be reset together with this block.
- Capture pipeline:
  - bram_en_in is delayed through a READ_LATENCY-deep shift register to form cap_valid.
  - When cap_valid=1, bram_dout is sampled in that same cycle.
- Push: on cap_valid, bram_dout is written at wr_ptr.
  - If the FIFO is full and there is no pop this cycle, the word is dropped and err_overflow is set.
  - Full with a same-cycle pop: push is accepted and count is unchanged.
- Pop:
  - out_valid = (count != 0); out_data = mem[rd_ptr] (FWFT).
  - Pop occurs when out_valid && out_ready; popping an empty FIFO is impossible.
- Latency: a word captured in cycle T is visible on out_data/out_valid in cycle T+1; bram_en_in to out_valid is READ_LATENCY+1 cycles.
- Credit and outstanding count:
  - outstanding counts words reserved but not yet captured.
  - start_fetch_in && fetch_allow: outstanding += WORDS_PER_TILE.
  - Each capture: outstanding -= 1. If outstanding is already 0, set err_unexpected; outstanding stays 0 and the word is still pushed if space allows.
  - Start and capture in the same cycle: net change is +WORDS_PER_TILE-1.
  - start_fetch_in && !fetch_allow: set err_overrun; no reservation is made.
  - fetch_allow = (FIFO_DEPTH - count - outstanding) >= WORDS_PER_TILE. It is combinational from registers, with no input-to-output path.
- Tile framing:
  - The pop word counter pw counts pops modulo WORDS_PER_TILE.
  - out_last = out_valid && (pw == WORDS_PER_TILE-1).
  - A pop with out_last=1 wraps pw to 0 and increments tile_count, which wraps naturally.
- Error flags: all err_* are sticky until rst; they never block the datapath.

Decomposition:
- Shared package fetch_pkg:
  - DATA_WIDTH and WORDS_PER_TILE constants.
  - A $clog2-derived pointer-width helper constant, shared with the fetch logic so tile size is defined once.
- One sub-module, sync_fifo_fwft:
  - Parameters DEPTH and WIDTH.
  - Ports push, pop, din, dout, count, full, empty.
- The top holds the latency shift register, the credit counter, framing and error flags.

Test Plan:
- Single tile, out_ready=1, READ_LATENCY=1: preload words 0..31 with value=index, pulse start_fetch_in, 32 reads issued -> out_data 0..31 in order, first out_valid 2 cycles after the first bram_en_in, out_last only on word 31, tile_count=1, fetch_allow returns to 1.
- Backpressure with out_ready=0, FIFO_DEPTH=64:
  - Tiles 1 and 2 start -> fetch_allow=1 after tile 1 and 0 after tile 2; fifo_count=64 with no errors.
  - Release out_ready -> 64 words with out_last at words 31 and 63; tile_count=2.
- Overrun: with fetch_allow=0, pulse start_fetch_in -> err_overrun=1, outstanding unchanged, the data stream is unaffected.
- Unexpected capture: bram_en_in pulse with no reservation -> err_unexpected=1, word appears on out_data, fifo_count=1.
- Reset mid-tile: rst after 10 of 32 captures -> next cycle fifo_count=0, out_valid=0, fetch_allow=1, err_*=0. A fresh tile then streams 32 clean words with out_last on word 31.
- Random out_ready at 50% with READ_LATENCY=2 over 8 tiles -> scoreboard matches all 256 words, tile_count=8, all err_* remain 0.
